// File: rtl/seq_det_event_logger_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger_pkg
//   Shared defaults for the 1001-detector event logger: timestamp width,
//   saturating counter width, FIFO depth and the detector -> logger link width.
//   No ports (package).
// -----------------------------------------------------------------------------
package seq_det_event_logger_pkg;

    localparam int DEF_TS_WIDTH   = 16;
    localparam int DEF_CNT_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // The detector drives a single detect line into the logger.
    localparam int DET_WIDTH      = 1;

    // Width needed to represent 0..depth queued entries.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/seq_det_event_logger_event_fifo.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger_event_fifo
//   Circular buffer of timestamps with show-ahead head output.
//   Pointers carry one extra wrap bit so full/empty are told apart without a
//   separate counter; level is simply the pointer difference.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous flush; overrides push and pop
//   push, din      write din at the tail (caller guarantees room, or a pop)
//   pop            advance the head (caller guarantees non-empty)
//   full, empty    occupancy flags
//   head           entry at the head, 0 while empty
//   level          number of entries queued
// -----------------------------------------------------------------------------
module seq_det_event_logger_event_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: head is masked to 0 whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (level == (AW+1)'(DEPTH));
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// seq_det_event_logger
//   Consumes the 1001 detector output. Every rising edge of det_in (while
//   enabled) is stamped with a free-running cycle counter and queued; the queue
//   drains over evt_valid/evt_ready. Also keeps a saturating event count and a
//   sticky flag for events lost to a full queue.
// Ports
//   clk, reset_n   clock, asynchronous active-low reset
//   enable         timestamp runs and events are captured while high
//   clear          synchronous clear of ts, queue, count and overflow
//   det_in         detector output y
//   evt_ready      consumer takes the head entry
//   evt_valid      queue non-empty
//   evt_ts         timestamp at the queue head (0 when empty)
//   evt_count      total events seen, including dropped ones, saturating
//   overflow       sticky: an event was dropped on a full queue
//   fifo_level     entries currently queued
// -----------------------------------------------------------------------------
module seq_det_event_logger
    import seq_det_event_logger_pkg::*;
#(
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          det_in,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [TS_WIDTH-1:0]           evt_ts,
    output logic [CNT_WIDTH-1:0]          evt_count,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    logic                det_q;
    logic [TS_WIDTH-1:0] ts;
    logic                evt;
    logic                pop;
    logic                push;
    logic                drop;
    logic                full;
    logic                empty;

    assign evt  = enable & det_in & ~det_q;
    // A clear cycle swallows both the incoming event and any handshake.
    assign pop  = evt_valid & evt_ready & ~clear;
    assign push = evt & (~full | pop) & ~clear;
    assign drop = evt & full & ~pop & ~clear;

    // det_q tracks det_in even while disabled so re-enabling on a held-high
    // line does not look like a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) det_q <= 1'b0;
        else          det_q <= det_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts        <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            ts        <= '0;
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (enable) ts <= ts + 1'b1;
            if (evt && (evt_count != {CNT_WIDTH{1'b1}})) evt_count <= evt_count + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    seq_det_event_logger_event_fifo #(
        .WIDTH (TS_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (ts),
        .full    (full),
        .empty   (empty),
        .head    (evt_ts),
        .level   (fifo_level)
    );

    assign evt_valid = ~empty;

endmodule

// File: tb/tb_seq_det_event_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_det_event_logger
//   Two logger instances share one stimulus stream: a default-width one and a
//   narrow one (4-bit timestamp, 3-bit count) so wrap and saturation show up.
//   A queue-based reference model predicts both every cycle.
// -----------------------------------------------------------------------------
module tb_seq_det_event_logger;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic det_in = 1'b0;
    logic evt_ready = 1'b0;

    logic        b_valid, b_ovf;
    logic [15:0] b_ts;
    logic [7:0]  b_cnt;
    logic [2:0]  b_lvl;
    logic        s_valid, s_ovf;
    logic [3:0]  s_ts;
    logic [2:0]  s_cnt;
    logic [2:0]  s_lvl;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int mq[$];
    int m_ts    = 0;
    int m_total = 0;
    bit m_ovf   = 1'b0;
    bit m_prev  = 1'b0;

    typedef struct {
        bit en;
        bit clr;
        bit din;
        bit rdy;
        bit v;
        int lvl;
        int ts;
        int cnt;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    seq_det_event_logger #(.TS_WIDTH(16), .CNT_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .det_in(det_in), .evt_ready(evt_ready), .evt_valid(b_valid),
        .evt_ts(b_ts), .evt_count(b_cnt), .overflow(b_ovf), .fifo_level(b_lvl)
    );

    seq_det_event_logger #(.TS_WIDTH(4), .CNT_WIDTH(3), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
        .det_in(det_in), .evt_ready(evt_ready), .evt_valid(s_valid),
        .evt_ts(s_ts), .evt_count(s_cnt), .overflow(s_ovf), .fifo_level(s_lvl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ts = 0;
        m_total = 0;
        m_ovf = 1'b0;
        m_prev = 1'b0;
    endtask

    // One clock edge of the logger, written from the behavioural rules.
    task automatic model_edge();
        bit ev;
        ev = enable && det_in && !m_prev;
        if (clear) begin
            mq.delete();
            m_ts = 0;
            m_total = 0;
            m_ovf = 1'b0;
        end else begin
            if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
            if (ev) begin
                m_total++;
                if (mq.size() < 4) mq.push_back(m_ts);
                else m_ovf = 1'b1;
            end
            if (enable) m_ts = (m_ts + 1) % 65536;
        end
        m_prev = det_in;
    endtask

    task automatic check_all();
        int h;
        h = (mq.size() > 0) ? mq[0] : 0;
        chk("b_valid", b_valid, mq.size() != 0);
        chk("b_level", b_lvl, mq.size());
        chk("b_ts", b_ts, h % 65536);
        chk("b_count", b_cnt, (m_total > 255) ? 255 : m_total);
        chk("b_overflow", b_ovf, m_ovf);
        chk("s_valid", s_valid, mq.size() != 0);
        chk("s_level", s_lvl, mq.size());
        chk("s_ts", s_ts, h % 16);
        chk("s_count", s_cnt, (m_total > 7) ? 7 : m_total);
        chk("s_overflow", s_ovf, m_ovf);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic pulse();
        det_in = 1'b1;
        step();
        det_in = 1'b0;
        step();
    endtask

    task automatic do_clear();
        enable = 1'b1;
        clear = 1'b1;
        det_in = 1'b0;
        evt_ready = 1'b0;
        step();
        clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bits[7];
        int exp_stamp;
        logic [3:0] hist;
        bit y;

        // reset state
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // table-driven vectors from reset (ts starts at 0)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 7, 2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            enable    = tbl[i].en;
            clear     = tbl[i].clr;
            det_in    = tbl[i].din;
            evt_ready = tbl[i].rdy;
            step();
            chk("tbl_valid", b_valid, tbl[i].v);
            chk("tbl_level", b_lvl, tbl[i].lvl);
            chk("tbl_ts", b_ts, tbl[i].ts);
            chk("tbl_count", b_cnt, tbl[i].cnt);
            chk("tbl_overflow", b_ovf, 1'b0);
        end

        // async reset with two entries queued
        do_clear();
        pulse();
        pulse();
        chk("rst_pre_level", b_lvl, 2);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_ts_now", b_ts, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("rst_valid_after", b_valid, 1'b0);

        // 1001 through a Moore detector model; y drives det_in
        do_clear();
        bits = '{1, 0, 0, 1, 0, 0, 0};
        hist = 4'b0000;
        y = 1'b0;
        exp_stamp = -1;
        for (int k = 0; k < 7; k++) begin
            det_in = y;
            if (y && exp_stamp < 0) exp_stamp = k;
            step();
            hist = {hist[2:0], bits[k][0]};
            y = (hist == 4'b1001);
        end
        det_in = 1'b0;
        chk("moore_stamp", b_ts, exp_stamp);
        chk("moore_count", b_cnt, 1);
        chk("moore_level", b_lvl, 1);

        // five events into a depth-4 queue, no draining
        do_clear();
        repeat (5) pulse();
        chk("ovf_level", b_lvl, 4);
        chk("ovf_flag", b_ovf, 1'b1);
        chk("ovf_count", b_cnt, 5);
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_drain", b_ts, 2 * i);
            step();
        end
        evt_ready = 1'b0;
        chk("ovf_empty", b_valid, 1'b0);

        // full queue, event and pop in the same cycle
        do_clear();
        repeat (4) pulse();
        det_in = 1'b1;
        evt_ready = 1'b1;
        step();
        det_in = 1'b0;
        chk("fullpp_level", b_lvl, 4);
        chk("fullpp_ovf", b_ovf, 1'b0);
        chk("fullpp_head", b_ts, 2);
        for (int i = 0; i < 4; i++) begin
            chk("fullpp_drain", b_ts, 2 + 2 * i);
            step();
        end
        evt_ready = 1'b0;

        // saturation on the narrow counter
        do_clear();
        repeat (9) pulse();
        chk("sat_small", s_cnt, 7);
        chk("sat_big", b_cnt, 9);

        // narrow timestamp wrap: stamps 15 then 0
        do_clear();
        repeat (15) step();
        det_in = 1'b1;
        step();
        enable = 1'b0;
        det_in = 1'b0;
        step();
        enable = 1'b1;
        det_in = 1'b1;
        step();
        det_in = 1'b0;
        chk("wrap_first", s_ts, 15);
        evt_ready = 1'b1;
        step();
        chk("wrap_second", s_ts, 0);
        chk("wrap_second_big", b_ts, 16);
        repeat (2) step();
        evt_ready = 1'b0;

        // randomized traffic against the model
        do_clear();
        for (int i = 0; i < 2000; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            det_in    = $urandom_range(0, 1);
            evt_ready = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
